// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard sequencer for the 5-stage RV32 core with a multi-cycle
// multiplier. It generates PC / IF-ID / ID-EX hold, bubble and flush controls
// for hazards that the forwarding unit cannot cover:
//   - load-use hazards (one-cycle stall plus ID/EX bubble)
//   - multi-cycle MUL occupancy of EX (stall upstream, bubble into EX/MEM)
//   - taken-branch flushes of IF/ID and ID/EX
//
// Ports:
//   clk               core clock, rising edge
//   arst_n            asynchronous active-low reset
//   instruction_ID    instruction currently in ID
//   instruction_EX    instruction currently in EX
//   MemRead_EX        EX instruction is a load
//   branch_taken_EX   EX branch/jump resolved taken this cycle
//   stall_pc          hold PC
//   stall_ifid        hold IF/ID register
//   stall_idex        hold ID/EX register
//   bubble_idex       load NOP into ID/EX
//   bubble_exmem      load NOP into EX/MEM
//   flush_ifid        replace IF/ID with NOP
//   flush_idex        replace ID/EX with NOP
//   mul_busy          registered, high while the FSM is in MUL_BUSY
//   stall_cycles      (HAZARD_STALL_CNT_EN only) saturating count of stall_pc cycles
//   flush_events      (HAZARD_STALL_CNT_EN only) saturating count of flush_ifid cycles
//
// Optional build macro: HAZARD_STALL_CNT_EN adds the two performance counters.
// Control behaviour is identical with or without it.
//
// FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal issue; MUL, branch flush and load-use are evaluated
//   MUL_BUSY | MUL holding EX; cnt counts remaining stalled cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = $clog2(MUL_LATENCY) + 1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [31:0] instruction_ID,
    input  logic [31:0] instruction_EX,
    input  logic        MemRead_EX,
    input  logic        branch_taken_EX,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        bubble_idex,
    output logic        bubble_exmem,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        mul_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    // The first stalled MUL cycle is spent in RUN, so the countdown is
    // loaded with LATENCY-2 and the cnt==0 cycle is the unstalled release.
    localparam bit              MUL_STALLS = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = MUL_STALLS ? CNT_W'(MUL_LATENCY - 2) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mul_busy_q;

    logic [4:0] rd_ex;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       is_mul_ex;
    logic       uses_rs2_id;
    logic       load_use;

    assign rd_ex  = instruction_EX[11:7];
    assign rs1_id = instruction_ID[19:15];
    assign rs2_id = instruction_ID[24:20];

    // MUL, MULH, MULHSU, MULHU only; the divide group (funct3[2]=1) is excluded.
    assign is_mul_ex = (instruction_EX[6:0]   == 7'b0110011) &&
                       (instruction_EX[31:25] == 7'b0000001) &&
                       (instruction_EX[14]    == 1'b0);

    // R-type, store and branch read rs2; I-type carries an immediate there.
    assign uses_rs2_id = (instruction_ID[6:0] == 7'b0110011) ||
                         (instruction_ID[6:0] == 7'b0100011) ||
                         (instruction_ID[6:0] == 7'b1100011);

    assign load_use = MemRead_EX && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction_ID[31:25], instruction_ID[14:7],
                                 instruction_EX[24:15]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;

        case (state_q)
            RUN: begin
                if (is_mul_ex && MUL_STALLS) begin
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    stall_idex   = 1'b1;
                    bubble_exmem = 1'b1;
                    state_d      = MUL_BUSY;
                    cnt_d        = CNT_LOAD;
                end else if (branch_taken_EX) begin
                    // The ID instruction is discarded, so any load-use on it is moot.
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    stall_idex   = 1'b1;
                    bubble_exmem = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
        endcase

        // Holding ID/EX takes precedence over inserting a bubble into it.
        bubble_idex = bubble_idex & ~stall_idex;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            mul_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_busy_q <= (state_d == MUL_BUSY);
        end
    end

    assign mul_busy = mul_busy_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush_ifid && (flush_events_q != 32'hFFFF_FFFF)) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int          LAT = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] instruction_ID = NOP;
    logic [31:0] instruction_EX = NOP;
    logic        MemRead_EX = 1'b0;
    logic        branch_taken_EX = 1'b0;
    logic        stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem;
    logic        flush_ifid, flush_idex, mul_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    hazard_stall_ctrl #(.MUL_LATENCY(LAT)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .instruction_ID (instruction_ID),
        .instruction_EX (instruction_EX),
        .MemRead_EX     (MemRead_EX),
        .branch_taken_EX(branch_taken_EX),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .stall_idex     (stall_idex),
        .bubble_idex    (bubble_idex),
        .bubble_exmem   (bubble_exmem),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .mul_busy       (mul_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

    always #5 clk = ~clk;

    // {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, flush_idex}
    logic [6:0] ctl;
    assign ctl = {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, flush_idex};

    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_LU    = 7'b110_1000;
    localparam logic [6:0] C_MUL   = 7'b111_0100;
    localparam logic [6:0] C_FLUSH = 7'b000_0011;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return enc(7'd0, 5'd0, rs1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return enc(7'd0, rs2, rs1, 3'b000, rd, 7'b0110011);
    endfunction
    function automatic logic [31:0] i_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return enc(7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011);
    endfunction
    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] imm);
        return enc(7'd0, imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    // Random instruction from a small register window so dependences are common.
    function automatic logic [31:0] rnd_instr();
        logic [4:0] a, b, c;
        int k;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        case (k)
            0, 1:    return NOP;
            2, 3, 4: return i_lw(a, b);
            5:       return i_mul(a, b, c);
            6:       return enc(7'($urandom_range(0, 1)), c, b, 3'($urandom_range(0, 7)), a, 7'b0110011);
            7:       return i_addi(a, b, c);
            8:       return enc(7'd0, c, b, 3'b010, 5'd0, 7'b0100011);
            default: return enc(7'd0, c, b, 3'b000, 5'd0, 7'b1100011);
        endcase
    endfunction

    // Reference model: decode rules plus "how many cycles has this MUL been in EX".
    function automatic bit m_is_mul(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001) && (int'(i[14:12]) <= 3);
    endfunction

    function automatic bit m_load_use(input logic [31:0] ex, input logic [31:0] id, input logic mr);
        int  rd;
        bit  reads_rs2;
        rd = int'(ex[11:7]);
        reads_rs2 = (id[6:0] == 7'b0110011) || (id[6:0] == 7'b0100011) || (id[6:0] == 7'b1100011);
        return mr && (rd != 0) && ((rd == int'(id[19:15])) || (reads_rs2 && rd == int'(id[24:20])));
    endfunction

    task automatic step(input logic [31:0] ex, input logic [31:0] id, input logic mr, input logic bt);
        @(negedge clk);
        instruction_EX  = ex;
        instruction_ID  = id;
        MemRead_EX      = mr;
        branch_taken_EX = bt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        instruction_EX  = NOP;
        instruction_ID  = NOP;
        MemRead_EX      = 1'b0;
        branch_taken_EX = 1'b0;
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         p;
        logic [31:0] ex, id;
        logic        mr, bt;
        logic [6:0]  exp_ctl;
        logic        exp_busy;

        // Reset state with NOP inputs
        #12;
        chk("reset_ctl", 32'(ctl), 32'(C_NONE));
        chk("reset_busy", 32'(mul_busy), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Load-use: lw x5,0(x1) in EX, add x6,x5,x2 in ID
        step(i_lw(5'd5, 5'd1), i_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
        chk("loaduse_stall", 32'(ctl), 32'(C_LU));
        step(NOP, i_add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
        chk("loaduse_release", 32'(ctl), 32'(C_NONE));

        // x0 destination never stalls
        step(i_lw(5'd0, 5'd1), i_add(5'd6, 5'd0, 5'd0), 1'b1, 1'b0);
        chk("x0_no_stall", 32'(ctl), 32'(C_NONE));
        // I-type immediate field equal to rd must not count as rs2
        step(i_lw(5'd7, 5'd1), i_addi(5'd8, 5'd0, 5'd7), 1'b1, 1'b0);
        chk("imm_rs2_no_stall", 32'(ctl), 32'(C_NONE));
        // rs2 dependence on an R-type does stall
        step(i_lw(5'd7, 5'd1), i_add(5'd8, 5'd3, 5'd7), 1'b1, 1'b0);
        chk("rs2_stall", 32'(ctl), 32'(C_LU));

        // MUL at t, back-to-back second MUL right after release
        for (int rep = 0; rep < 2; rep++) begin
            step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
            chk("mul_t0_ctl", 32'(ctl), 32'(C_MUL));
            chk("mul_t0_busy", 32'(mul_busy), 32'd0);
            step(i_mul(5'd3, 5'd1, 5'd2), i_add(5'd1, 5'd3, 5'd3), 1'b1, 1'b1);
            chk("mul_t1_ctl", 32'(ctl), 32'(C_MUL));
            chk("mul_t1_busy", 32'(mul_busy), 32'd1);
            step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b1);
            chk("mul_t2_ctl", 32'(ctl), 32'(C_NONE));
            chk("mul_t2_busy", 32'(mul_busy), 32'd1);
        end
        step(NOP, NOP, 1'b0, 1'b0);
        chk("mul_done_busy", 32'(mul_busy), 32'd0);

        // Branch flush overrides load-use
        step(i_lw(5'd5, 5'd1), i_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
        chk("flush_over_lu", 32'(ctl), 32'(C_FLUSH));

        // Reset in the middle of a MUL countdown
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        chk("midmul_busy_before", 32'(mul_busy), 32'd1);
        instruction_EX = NOP;
        arst_n = 1'b0;
        #1;
        chk("midmul_busy_async", 32'(mul_busy), 32'd0);
        chk("midmul_ctl_async", 32'(ctl), 32'(C_NONE));
        #1;
        arst_n = 1'b1;
        step(NOP, NOP, 1'b0, 1'b0);
        chk("post_rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("post_rst_busy", 32'(mul_busy), 32'd0);
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        chk("post_rst_mul_t0", 32'(ctl), 32'(C_MUL));
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        chk("post_rst_mul_t1", 32'(ctl), 32'(C_MUL));
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        chk("post_rst_mul_t2", 32'(ctl), 32'(C_NONE));

`ifdef HAZARD_STALL_CNT_EN
        // One load-use, one MUL and one flush from a clean reset
        do_reset();
        #1;
        chk("cnt_reset_stall", stall_cycles, 32'd0);
        chk("cnt_reset_flush", flush_events, 32'd0);
        step(i_lw(5'd5, 5'd1), i_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
        step(NOP, NOP, 1'b0, 1'b0);
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        step(i_mul(5'd3, 5'd1, 5'd2), NOP, 1'b0, 1'b0);
        step(NOP, NOP, 1'b0, 1'b1);
        step(NOP, NOP, 1'b0, 1'b0);
        chk("cnt_stall_cycles", stall_cycles, 32'd3);
        chk("cnt_flush_events", flush_events, 32'd1);
`endif

        // Randomized run against the occupancy model.
        // p = 0: EX free; p = k >= 2: k-th cycle the current MUL has held EX.
        do_reset();
        p = 0;
        for (int n = 0; n < 3000; n++) begin
            ex = rnd_instr();
            id = rnd_instr();
            mr = (ex[6:0] == 7'b0000011) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            bt = ($urandom_range(0, 5) == 0);
            step(ex, id, mr, bt);

            exp_busy = (p >= 2);
            if (p == 0) begin
                if (m_is_mul(ex) && LAT > 1) begin
                    exp_ctl = C_MUL;
                    p = 2;
                end else if (bt) begin
                    exp_ctl = C_FLUSH;
                end else if (m_load_use(ex, id, mr)) begin
                    exp_ctl = C_LU;
                end else begin
                    exp_ctl = C_NONE;
                end
            end else begin
                exp_ctl = (p < LAT) ? C_MUL : C_NONE;
                p = (p >= LAT) ? 0 : p + 1;
            end

            chk("rnd_ctl", 32'(ctl), 32'(exp_ctl));
            chk("rnd_busy", 32'(mul_busy), 32'(exp_busy));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage RV32 core with the 3-cycle multiplier (MULT3).
- Generates PC/IF-ID/ID-EX hold, bubble and flush controls for three cases: load-use hazards, multi-cycle MUL occupancy of EX, and taken-branch flushes.
- Sits beside the forwarding unit. The forwarding unit resolves the hazards that bypassing can cover; this block stalls or flushes for everything else.

Parameters:
- MUL_LATENCY, 3: number of cycles a MUL occupies EX; legal range 1..16.
- CNT_W, $clog2(MUL_LATENCY)+1: width of the internal MUL countdown register.

Ports:
- clk  input  1  core clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- instruction_ID  input  32  instruction in ID stage.
- instruction_EX  input  32  instruction in EX stage.
- MemRead_EX  input  1  EX instruction is a load.
- branch_taken_EX  input  1  EX branch/jump resolved taken this cycle.
- stall_pc  output  1  hold PC.
- stall_ifid  output  1  hold IF/ID register.
- stall_idex  output  1  hold ID/EX register.
- bubble_idex  output  1  load NOP into ID/EX.
- bubble_exmem  output  1  load NOP into EX/MEM.
- flush_ifid  output  1  replace IF/ID with NOP.
- flush_idex  output  1  replace ID/EX with NOP.
- mul_busy  output  1  registered; high while FSM is in MUL_BUSY.

Behaviour:
- Decode:
  - rd_EX = instruction_EX[11:7].
  - rs1_ID = instruction_ID[19:15].
  - rs2_ID = instruction_ID[24:20].
  - is_mul_EX = (opcode 0110011) and (funct7 0000001) and (funct3 000..011).
  - uses_rs2_ID = ID opcode is 0110011, 0100011 or 1100011.
- FSM states: RUN, MUL_BUSY.
- Reset (async, arst_n low):
  - state = RUN, cnt = 0, mul_busy = 0.
  - All combinational outputs evaluate to 0 while the EX/ID inputs are NOP (0x00000013).
  - Reset asserted mid-MUL aborts the countdown immediately.
- RUN state:
  - If is_mul_EX and MUL_LATENCY>1: assert stall_pc, stall_ifid, stall_idex, bubble_exmem. Next state MUL_BUSY, cnt = MUL_LATENCY-2.
  - Else if branch_taken_EX: assert flush_ifid and flush_idex. No stall.
  - Else if load-use: assert stall_pc, stall_ifid, bubble_idex for exactly one cycle. Stay in RUN.
    - Load-use condition: MemRead_EX and rd_EX!=0 and (rd_EX==rs1_ID or (uses_rs2_ID and rd_EX==rs2_ID)).
  - Priority: MUL > branch flush > load-use. A flush cancels a pending load-use stall because the ID instruction is discarded.
- MUL_BUSY state:
  - cnt>0: assert stall_pc, stall_ifid, stall_idex, bubble_exmem; cnt decrements.
  - cnt==0: all stalls deasserted; the MUL result advances to MEM this cycle; next state RUN.
  - Any branch_taken_EX or load-use evaluation is suppressed in this state.
- Timing:
  - A MUL occupies EX for exactly MUL_LATENCY cycles, with MUL_LATENCY-1 of them stalled.
  - MUL_LATENCY==1: no stall, FSM never leaves RUN.
  - Back-to-back MULs: the second MUL enters EX the cycle after release. RUN detects it again with a full countdown and no lost cycle.
- Load-use stall:
  - Latency: stall outputs are combinational, valid in the same cycle as the detecting inputs.
  - After the one-cycle stall the load reaches MEM and the forwarding unit supplies the operand from WB on the next cycle.
- x0 handling: rd_EX==0 never triggers load-use.
- Combined stall and bubble: when stall_idex and bubble_idex would both be set, bubble_idex is 0. bubble_idex is only raised in RUN.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0]: counts cycles with stall_pc high.
  - Adds output flush_events [31:0]: counts cycles with flush_ifid high.
  - Both reset to 0 on arst_n, saturate at 0xFFFFFFFF, and are readable by the bench and the perf counter block.
- Undefined: the ports and counters do not exist. Control behaviour is identical in both builds.

Test Plan:
- Load-use:
  - Stimulus: EX=lw x5,0(x1) with MemRead_EX=1; ID=add x6,x5,x2.
  - Required: stall_pc=stall_ifid=bubble_idex=1 for 1 cycle, then all 0.
- x0 and rs2 exclusion:
  - Stimulus: lw x0 in EX with a dependent ID; then lw x7 with ID=addi x8,x0,7 (I-type, imm rs2 field=7).
  - Required: no stall in either case.
- MUL, MUL_LATENCY=3:
  - Stimulus: EX=mul x3,x1,x2 at cycle t.
  - Required: stall signals high at t and t+1, low at t+2. mul_busy high at t+1 and t+2. Back-to-back MUL repeats the pattern with no gap.
- Branch flush:
  - Stimulus: branch_taken_EX=1 while the ID instruction has a load-use dependence on the EX load.
  - Required: flush_ifid=flush_idex=1, stall_pc=0.
- Reset mid-MUL:
  - Stimulus: arst_n low during MUL_BUSY with cnt=1.
  - Required: mul_busy=0 immediately (async); after release, FSM in RUN.
- HAZARD_STALL_CNT_EN build:
  - Stimulus: one load-use plus one MUL (latency 3) plus one flush.
  - Required: stall_cycles=3, flush_events=1.
